// File: rtl/full_adder_behavioral.sv
// One-bit full-adder cell: the per-bit combinational stage shared by the serial adder.
module full_adder_behavioral (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus carry flop, WIDTH cycles per add.
// state | meaning
// IDLE  | waiting for start; last result held on sum/carry_out
// RUN   | one bit pair added per cycle, busy=1
// DONE  | one-cycle done pulse; start here is accepted like IDLE
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a, sh_b, acc, acc_nxt;
  logic [WIDTH:0]   acc_ext;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry, last_bit, load;

  full_adder_behavioral u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_carry)
  );

  // New bit enters at the MSB; written via a wide concat so WIDTH=1 needs no empty slice.
  assign acc_ext  = {fa_sum, acc};
  assign acc_nxt  = acc_ext[WIDTH:1];
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN:     if (last_bit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      acc       <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sh_a    <= a;
        sh_b    <= b;
        carry_q <= carry_in;
        cnt     <= '0;
        acc     <= '0;
      end else if (state_q == RUN) begin
        sh_a    <= sh_a >> 1;
        sh_b    <= sh_b >> 1;
        carry_q <= fa_carry;
        acc     <= acc_nxt;
        cnt     <= cnt + CW'(1);
        // Publish the whole result at once, straight from the final bit, so done lands at WIDTH+1.
        if (last_bit) begin
          sum       <= acc_nxt;
          carry_out <= fa_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances, vector table + random ops.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, co1;
  logic [0:0] a1, b1, sum1;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .carry_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .carry_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Caller sits 1 time unit after a rising edge. Returns cycles from start to done
  // (0 on timeout) and the number of busy cycles seen; optional junk start pulses while busy.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                     input bit noise, output int lat, output int nbusy);
    logic [7:0] held;
    held  = sum8;
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0; nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy8 && done8) chk("busy_done_overlap8", 1, 0);
      if (done8) begin lat = k; break; end
      if (busy8) nbusy++;
      if (k == 4) chk("sum_hold_during_run", {23'd0, sum8}, {23'd0, held});
      start8 = (noise && k < 8) ? 1'($urandom) : 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
    end
    start8 = 1'b0;
  endtask

  task automatic op1(input logic ia, input logic ib, input logic ic, output int lat);
    a1 = ia; b1 = ib; cin1 = ic; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (busy1 && done1) chk("busy_done_overlap1", 1, 0);
      if (done1) begin lat = k; break; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat, nb, pulses, first;
    logic [8:0] e9;
    logic [1:0] e2;

    vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vt[3] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};
    vt[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

    rst = 1'b1; start8 = 0; start1 = 0;
    a8 = 0; b8 = 0; cin8 = 0; a1 = 0; b1 = 0; cin1 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    chk("reset_sum", sum8, 0);
    chk("reset_cout", co8, 0);

    // Vector table
    foreach (vt[i]) begin
      op8(vt[i].a, vt[i].b, vt[i].c, 1'b0, lat, nb);
      chk($sformatf("vec%0d_latency", i), lat, 9);
      chk($sformatf("vec%0d_busy_cycles", i), nb, 8);
      chk($sformatf("vec%0d_sum", i), sum8, vt[i].s);
      chk($sformatf("vec%0d_cout", i), co8, vt[i].co);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done8, 0);
    chk("sum_hold_idle", sum8, 8'h00);

    // Start while busy must be ignored
    a8 = 8'h10; b8 = 8'h20; cin8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (3) begin @(posedge clk); #1; end
    a8 = 8'hAA; b8 = 8'h55; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    pulses = 0; first = 0;
    for (int k = 5; k <= 16; k++) begin
      if (done8) begin
        pulses++;
        if (first == 0) begin
          first = k;
          chk("ignored_start_sum", sum8, 8'h30);
          chk("ignored_start_cout", co8, 0);
        end
      end
      @(posedge clk); #1;
    end
    chk("ignored_start_done_cycle", first, 9);
    chk("ignored_start_pulses", pulses, 1);

    // Back-to-back start in the done cycle
    op8(8'h01, 8'h01, 1'b0, 1'b0, lat, nb);
    chk("b2b_first_sum", sum8, 8'h02);
    a8 = 8'h80; b8 = 8'h80; cin8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    chk("b2b_busy_again", busy8, 1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done8) begin lat = k; break; end
      @(posedge clk); #1;
    end
    chk("b2b_second_gap", lat, 9);
    chk("b2b_second_sum", sum8, 8'h00);
    chk("b2b_second_cout", co8, 1);

    // Reset mid-run
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, lat, nb);
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    chk("midrst_sum", sum8, 0);
    chk("midrst_cout", co8, 0);
    pulses = 0;
    repeat (12) begin
      if (done8) pulses++;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", pulses, 0);
    op8(8'hC3, 8'h4E, 1'b1, 1'b0, lat, nb);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_sum", {co8, sum8}, 9'h112);

    // Randomized against arithmetic reference
    for (int n = 0; n < 25; n++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      e9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op8(ra, rb, rc, 1'b1, lat, nb);
      chk("rand_latency", lat, 9);
      chk("rand_result", {co8, sum8}, e9);
    end

    // WIDTH=1 instance: exhaustive
    for (int i = 0; i < 8; i++) begin
      logic [2:0] iv;
      iv = 3'(i);
      e2 = {1'b0, iv[2]} + {1'b0, iv[1]} + {1'b0, iv[0]};
      op1(iv[2], iv[1], iv[0], lat);
      chk($sformatf("w1_%0d_latency", i), lat, 2);
      chk($sformatf("w1_%0d_result", i), {co1, sum1}, e2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder, LSB first. Adds two WIDTH-bit operands plus carry-in over WIDTH clock cycles using one full-adder cell and a carry flip-flop.
- Sits upstream of the full-adder cell: it owns the operand shift registers, carry storage, bit counter and start/done handshake, and feeds one bit pair per cycle into the cell.
- Area-cheap alternative to a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request; sampled only when not busy.
- a, input, WIDTH, operand A; captured on accepted start.
- b, input, WIDTH, operand B; captured on accepted start.
- carry_in, input, 1, initial carry; captured on accepted start.
- busy, output, 1, high while serial addition is in progress.
- done, output, 1, one-cycle pulse when the result is ready.
- sum, output, WIDTH, registered result.
- carry_out, output, 1, registered final carry.

Behaviour:
- Reset: when rst is sampled high at a clock edge, the block goes to IDLE. busy=0, done=0, sum=0, carry_out=0; shift registers, carry flip-flop and counter are cleared. rst has priority over everything.
- States:
  - IDLE: start=1 is accepted. Load a, b, carry_in, clear the counter, go to RUN.
  - RUN: each cycle, full-adder inputs are sh_a[0], sh_b[0], carry_q. The sum bit shifts into the MSB of the accumulator; sh_a and sh_b shift right; carry_q takes the full-adder carry; the counter increments. When the counter reaches WIDTH-1, that cycle's bit is the last one. On the next edge, sum and carry_out are updated from accumulator/carry and the block goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0. start=1 here is accepted exactly as in IDLE, going to RUN. Otherwise go to IDLE.
- Latency: start high in cycle 0 → busy high in cycles 1..WIDTH → done high in cycle WIDTH+1, with sum/carry_out valid in that same cycle.
- sum and carry_out change only on the completion edge. They hold their value through IDLE and through any later RUN until the next completion. They are never partially updated.
- start while busy=1 is ignored: not queued, no effect on the running operation.
- a, b and carry_in may change freely after the accepted start edge.
- Result equals (a + b + carry_in) mod 2^WIDTH. carry_out is bit WIDTH of the full sum.
- Counter width is $clog2(WIDTH+1). For WIDTH=1 the block makes one RUN cycle.
- Reset mid-RUN: operation aborted, no done pulse, sum/carry_out cleared to 0.
- done and busy are never high together.

Decomposition:
- No package needed. WIDTH is the only parameter; state encoding is a localparam (IDLE=0, RUN=1, DONE=2) inside the module.
- One sub-module: instantiate the existing full_adder_behavioral cell for the per-bit add. Keep all sequential logic in serial_adder.

Test Plan:
1. WIDTH=8: a=0x5A, b=0x3C, carry_in=0, start pulsed in cycle 0 → busy in cycles 1–8; done in cycle 9 with sum=0x96, carry_out=0.
2. a=0xFF, b=0x01, carry_in=0 → sum=0x00, carry_out=1. Then a=0xFF, b=0x00, carry_in=1 → sum=0x00, carry_out=1.
3. Start 0x10+0x20; in cycle 4 assert start with a=0xAA, b=0x55 → ignored; done in cycle 9 with sum=0x30, carry_out=0; exactly one done pulse.
4. Back-to-back: start asserted in the done cycle of 0x01+0x01 (sum=0x02) with new a=0x80, b=0x80 → busy again the next cycle; second done 9 cycles after the first with sum=0x00, carry_out=1.
5. Reset mid-op: rst high in cycle 5 of a RUN → next cycle busy=0, done=0, sum=0, carry_out=0; no done pulse follows. A fresh start afterwards computes correctly.
6. WIDTH=1 build, all 8 combinations of a, b, carry_in → done in cycle 2 each time; {carry_out, sum} equals a+b+carry_in.
